// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: start/done handshake, operands and result of the multiply/divide unit
interface ex_muldiv_unit_if #(parameter int XLEN = 32);
  logic start, flush, busy, done, stall_req;
  logic [2:0] op;
  logic [XLEN-1:0] a, b, result;
  modport master(output start, flush, op, a, b, input busy, done, result, stall_req);
  modport slave(input start, flush, op, a, b, output busy, done, result, stall_req);
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: multi-cycle RV32M multiply/divide; define MULDIV_FAST_MUL_EN for a single-cycle multiply
module ex_muldiv_unit #(parameter int XLEN = 32) (
  input logic clk,
  input logic rst,
  ex_muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state;
  logic [1:0] sel;
  logic neg, sa, sb, dz, ovf, last, mul_last, ge;
  logic [CW-1:0] cnt;
  logic [2*XLEN-1:0] acc, opa, prod, prod_s;
  logic [XLEN-1:0] opb, ma, mb, fast_res, mul_res, div_res, q_next, r_next;
  logic [XLEN:0] trial;
  assign bus.stall_req = bus.start & ~bus.done;
  always_comb begin
    sa = bus.a[XLEN-1] & (bus.op inside {3'b001, 3'b010, 3'b100, 3'b110});
    sb = bus.b[XLEN-1] & (bus.op inside {3'b001, 3'b100, 3'b110});
    ma = sa ? -bus.a : bus.a;
    mb = sb ? -bus.b : bus.b;
    dz = bus.op[2] & (bus.b == '0);
    ovf = (bus.op == 3'b100 || bus.op == 3'b110) && bus.a == {1'b1, {(XLEN-1){1'b0}}} && bus.b == '1;
    fast_res = dz ? (bus.op[1] ? bus.a : '1) : (bus.op[1] ? '0 : bus.a);
    last = cnt == CW'(XLEN - 1);
`ifdef MULDIV_FAST_MUL_EN
    prod = opa * {{XLEN{1'b0}}, opb};
    mul_last = 1'b1;
`else
    prod = acc + (opb[0] ? opa : '0);
    mul_last = last;
`endif
    prod_s = neg ? -prod : prod;
    mul_res = sel == 2'b00 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    // restoring step: acc holds {partial remainder, dividend/quotient}
    trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    ge = trial >= {1'b0, opa[XLEN-1:0]};
    r_next = ge ? XLEN'(trial - {1'b0, opa[XLEN-1:0]}) : trial[XLEN-1:0];
    q_next = {acc[XLEN-2:0], ge};
    div_res = sel[1] ? (neg ? -r_next : r_next) : (neg ? -q_next : q_next);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.result <= '0;
      acc <= '0;
      opa <= '0;
      opb <= '0;
      cnt <= '0;
      sel <= '0;
      neg <= 1'b0;
    end else if (bus.flush) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          sel <= bus.op[1:0];
          neg <= bus.op == 3'b110 ? sa : sa ^ sb;
          cnt <= '0;
          acc <= bus.op[2] ? {{XLEN{1'b0}}, ma} : '0;
          opa <= {{XLEN{1'b0}}, bus.op[2] ? mb : ma};
          opb <= mb;
          if (dz | ovf) begin
            bus.result <= fast_res;
            bus.done <= 1'b1;
            state <= DONE;
          end else begin
            bus.busy <= 1'b1;
            state <= bus.op[2] ? DIV : MUL;
          end
        end
        MUL: if (mul_last) begin
          bus.result <= mul_res;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state <= DONE;
        end else begin
          acc <= prod;
          opa <= opa << 1;
          opb <= opb >> 1;
          cnt <= cnt + 1'b1;
        end
        DIV: begin
          acc <= {r_next, q_next};
          cnt <= cnt + 1'b1;
          if (last) begin
            bus.result <= div_res;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: vector table, random ops against an arithmetic model, flush/reset/back-to-back sequences
module tb_ex_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 2;
`else
  localparam int ML = 33;
`endif
  logic clk = 1'b0;
  logic rst;
  int checks = 0, failures = 0, stall_bad = 0;
  ex_muldiv_unit_if #(.XLEN(32)) bus();
  ex_muldiv_unit #(.XLEN(32)) dut(.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [31:0] a, b, exp;
    int lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      3'b000: p = ux * uy;
      3'b001: p = sx * sy;
      3'b010: p = sx * uy;
      3'b011: p = ux * uy;
      3'b100: p = y == 0 ? 64'hFFFFFFFF : (x == 32'h80000000 && y == '1) ? {32'b0, x} : 64'(sx / sy);
      3'b101: p = y == 0 ? 64'hFFFFFFFF : 64'(ux / uy);
      3'b110: p = y == 0 ? {32'b0, x} : (x == 32'h80000000 && y == '1) ? 64'd0 : 64'(sx % sy);
      default: p = y == 0 ? {32'b0, x} : 64'(ux % uy);
    endcase
    return o == 3'b000 || o[2] ? p[31:0] : p[63:32];
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && (y == 0 || (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF))) return 1;
    return o[2] ? 33 : ML;
  endfunction

  // called at a negedge with the unit idle; returns one cycle after done, back in IDLE
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output int lat);
    bus.op = o;
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    lat = -1;
    #1 if (!bus.stall_req) stall_bad++;
    for (int k = 1; k <= 200 && lat < 0; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        if (bus.stall_req) stall_bad++;
      end else if (!bus.stall_req) stall_bad++;
    end
    r = bus.result;
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] res, prev, sp [4];
  int lat, nd, dcyc [2];
  logic [31:0] dres [2];
  logic seen_done;
  vec_t vt [$];

  initial begin
    vt.push_back('{3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, ML});
    vt.push_back('{3'b001, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, ML});
    vt.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ML});
    vt.push_back('{3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, ML});
    vt.push_back('{3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33});
    vt.push_back('{3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33});
    vt.push_back('{3'b101, 32'd100, 32'd7, 32'd14, 33});
    vt.push_back('{3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1});
    vt.push_back('{3'b111, 32'd5, 32'd0, 32'd5, 1});
    vt.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vt.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1});
    vt.push_back('{3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33});
    vt.push_back('{3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 33});
    vt.push_back('{3'b110, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1});
    vt.push_back('{3'b111, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 33});
    sp = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000};
    rst = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_result", bus.result, 0);
    rst = 1'b1;
    @(negedge clk);

    foreach (vt[i]) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, res, lat);
      check($sformatf("vec%0d_result", i), res, vt[i].exp);
      check($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      check($sformatf("vec%0d_hold", i), bus.result, vt[i].exp);
    end

    for (int n = 0; n < 40; n++) begin
      logic [2:0] o;
      logic [31:0] x, y;
      o = 3'($urandom_range(0, 7));
      x = $urandom_range(0, 3) == 0 ? sp[$urandom_range(0, 3)] : $urandom;
      y = $urandom_range(0, 3) == 0 ? sp[$urandom_range(0, 3)] : $urandom;
      run_op(o, x, y, res, lat);
      check($sformatf("rand%0d_op%0d_%h_%h", n, o, x, y), res, ref_op(o, x, y));
      check($sformatf("rand%0d_latency", n), lat, exp_lat(o, x, y));
    end

    // flush mid-divide: start in cycle 0, flush in cycle 10
    run_op(3'b101, 32'd77, 32'd7, prev, lat);
    bus.op = 3'b100;
    bus.a = 32'd1000;
    bus.b = 32'd3;
    bus.start = 1'b1;
    seen_done = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      seen_done |= bus.done;
    end
    bus.flush = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    seen_done |= bus.done;
    bus.flush = 1'b0;
    check("flush_idle_busy", bus.busy, 0);
    check("flush_no_done", seen_done, 0);
    check("flush_result_kept", bus.result, prev);
    @(negedge clk);
    check("flush_no_done_late", bus.done, 0);
    run_op(3'b101, 32'd9, 32'd3, res, lat);
    check("after_flush_result", res, 3);
    check("after_flush_latency", lat, 33);

    // flush in IDLE blocks acceptance of start
    bus.op = 3'b101;
    bus.a = 32'd50;
    bus.b = 32'd5;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("idle_flush_blocks_start", {bus.busy, bus.done}, 0);
    @(negedge clk);

    // asynchronous reset in cycle 5 of a multiply
    bus.op = 3'b000;
    bus.a = 32'h1234;
    bus.b = 32'h55;
    bus.start = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midop_reset_busy", bus.busy, 0);
    check("midop_reset_done", bus.done, 0);
    check("midop_reset_result", bus.result, 0);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_no_done", bus.done, 0);

    // start held high across two multiplies
    bus.op = 3'b000;
    bus.a = 32'd6;
    bus.b = 32'd7;
    bus.start = 1'b1;
    nd = 0;
    dcyc = '{-1, -1};
    dres = '{32'hX, 32'hX};
    for (int k = 1; k <= 150 && nd < 2; k++) begin
      @(negedge clk);
      if (bus.done) begin
        dcyc[nd] = k;
        dres[nd] = bus.result;
        nd++;
        bus.a = 32'd2;
        bus.b = 32'd3;
      end
    end
    bus.start = 1'b0;
    check("b2b_done1_cycle", dcyc[0], ML);
    check("b2b_result1", dres[0], 42);
    check("b2b_done2_cycle", dcyc[1], 2 * ML + 1);
    check("b2b_result2", dres[1], 6);
    check("stall_req_profile", stall_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Parametrised multi-cycle multiply/divide unit for the execute stage, implementing the RV32M `funct3` operations for operands of width `XLEN`. It accepts one operation at a time via a start/done handshake and raises a combinational stall request so IF/ID/EX hold while it iterates. A taken branch can flush it mid-operation. It sits beside the single-cycle ALU, and its result is muxed into the EX/MEM `alu_out` register on the `done` cycle.

## Interface
Parameters:
- `XLEN`, 32, operand and result width (even, ≥ 8).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `start`  in  1  operation request; held high with stable `op`/`a`/`b` until `done`.
- `flush`  in  1  abort the current operation (synchronous).
- `op`  in  3  `000` mul, `001` mulh, `010` mulhsu, `011` mulhu, `100` div, `101` divu, `110` rem, `111` remu.
- `a`  in  XLEN  rs1 operand (post-forwarding).
- `b`  in  XLEN  rs2 operand (post-forwarding).
- `busy`  out  1  high in MUL/DIV states.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  XLEN  registered result; held until the next `done`.
- `stall_req`  out  1  combinational `start & ~done`.

## Operation
- States: IDLE, MUL, DIV, DONE.
- **Reset** (`rst` low): state IDLE; `busy`=0, `done`=0, `result`=0; internal accumulator, counter and operand registers all 0.
- **IDLE**, `start`=1, `flush`=0: latch the operands and go to the next state per operation.
  - Multiply ops → MUL.
  - Divide/remainder ops → DIV.
  - Fast cases → DONE directly, with `result` loaded on the same edge:
    - Divide by zero (`b`==0): div/divu give all ones; rem/remu give `a`.
    - Signed overflow (`a`==`{1'b1,{XLEN-1{1'b0}}}`, `b`==all ones): div gives `a`; rem gives 0.
- **MUL**: shift-add over a 2·XLEN product on operand magnitudes.
  - One bit per cycle; the counter runs 0..XLEN-1.
  - Sign handling: mulh treats both operands as signed; mulhsu treats `a` as signed and `b` as unsigned; mul and mulhu use no sign correction.
  - The product is negated at the end when the operand signs differ.
  - mul returns the low XLEN bits; mulh/mulhsu/mulhu return the high XLEN bits.
- **DIV**: restoring division on magnitudes, one quotient bit per cycle, XLEN cycles.
  - Quotient sign = `sign(a)^sign(b)` (div).
  - Remainder sign = `sign(a)` (rem).
- **End of iteration**: on the last iteration edge, load `result` and go to DONE.
- **DONE**: `done`=1 for exactly one cycle, then IDLE unconditionally. `start` seen in that IDLE cycle belongs to the next instruction.
- **flush**: has priority over everything in any state; state returns to IDLE on the next edge.
  - `done` is not raised.
  - `result` keeps its previous value.
  - A `flush` in IDLE blocks acceptance of `start` that cycle.
- **Arithmetic**: all arithmetic is modulo 2^XLEN / 2^(2·XLEN). The counter is `$clog2(XLEN)+1` bits wide.

## Timing
- Cycle 0 is the cycle in which `start` is sampled in IDLE.
- Iterative ops: `busy` high in cycles 1..XLEN; `done` high in cycle XLEN+1, so latency is XLEN+1.
- Fast-path divide cases: `done` in cycle 1.
- `stall_req` is high in cycles 0..XLEN and low in the `done` cycle, so the pipeline advances on the edge that ends the `done` cycle.
- `rst` asserted mid-operation: outputs go to reset values immediately (asynchronously), and no `done` is produced.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: the MUL state computes the full 2·XLEN signed/unsigned product in one cycle using the `*` operator.
  - All multiply ops: `done` in cycle 2 (MUL for one cycle, then DONE).
  - Divide timing is unchanged.
- Not defined: multiply is the iterative shift-add above, with `done` in cycle XLEN+1.

## Test plan
- **Signed multiply** (XLEN=32, iterative): mul `a`=0xFFFFFFFD (-3), `b`=7 → `done` in cycle 33, `result`=0xFFFFFFEB; mulh with the same operands → 0xFFFFFFFF.
- **High-half variants**: mulhu `a`=0xFFFFFFFF, `b`=0xFFFFFFFF → 0xFFFFFFFE; mulhsu `a`=0xFFFFFFFF, `b`=2 → 0xFFFFFFFF.
- **Signed division**: div `a`=-7, `b`=2 → 0xFFFFFFFD; rem with the same operands → 0xFFFFFFFF; divu `a`=100, `b`=7 → 14, `done` in cycle 33.
- **Fast-path divide cases**:
  - divu `b`=0, `a`=5 → 0xFFFFFFFF in cycle 1; remu with the same operands → 5.
  - div 0x80000000 / 0xFFFFFFFF → 0x80000000 in cycle 1; rem with the same operands → 0.
- **Flush**: start div, assert `flush` in cycle 10 → IDLE at cycle 11, `done` never pulses, `result` unchanged; a new divu 9/3 started in cycle 12 → 3 in cycle 45.
- **Reset and back-to-back**: drop `rst` in cycle 5 of a mul → `busy`/`done`/`result` read 0 immediately. After `rst` rises, hold `start` high across two ops (mul 6×7 then mul 2×3) → `done` in cycles 33 and 67, results 42 then 6. With `MULDIV_FAST_MUL_EN` defined, the same sequence gives `done` in cycles 2 and 5.
